// File: rtl/neopix_decoder.sv
// rtl/neopix_decoder.sv - WS2812 GRB stream receiver; define NEOPIX_DEC_ERR_CNT_EN to add err_count
module neopix_decoder #(
    parameter int BIT_THRESH   = 30,
    parameter int MIN_HIGH     = 8,
    parameter int MAX_HIGH     = 60,
    parameter int LATCH_CYCLES = 2500,
    parameter int PIX_W        = 3
) (
    input  logic             CLOCK_50,
    input  logic             reset_n,
    input  logic             neopixel_data,
    output logic [7:0]       red,
    output logic [7:0]       green,
    output logic [7:0]       blue,
    output logic [PIX_W-1:0] pixel_index,
    output logic             pixel_valid,
    output logic             frame_done,
    output logic             error
`ifdef NEOPIX_DEC_ERR_CNT_EN
    ,
    output logic [7:0]       err_count
`endif
);
    localparam int HW = $clog2(MAX_HIGH + 2);
    localparam int LW = $clog2(LATCH_CYCLES + 1);
    localparam logic [HW-1:0] H_SAT  = HW'(MAX_HIGH + 1);
    localparam logic [HW-1:0] H_MIN  = HW'(MIN_HIGH);
    localparam logic [HW-1:0] H_MAX  = HW'(MAX_HIGH);
    localparam logic [HW-1:0] H_ONE  = HW'(BIT_THRESH);
    localparam logic [LW-1:0] L_LAST = LW'(LATCH_CYCLES - 1);
    localparam logic [LW-1:0] L_SAT  = LW'(LATCH_CYCLES);

    typedef enum logic [1:0] {WAIT_LATCH, IDLE, HIGH, LOW} state_t;
    state_t state, state_nxt;

    logic             sync1, s, s_d;
    logic             rise, fall;
    logic [HW-1:0]    hcnt;
    logic [LW-1:0]    lcnt;
    logic [23:0]      sr, sr_nxt;
    logic [4:0]       bitcnt;
    logic [PIX_W-1:0] word_idx;
    logic             bit_val, bit_ok, bit_bad, latch_hit, wait_done, err_evt;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
            s_d   <= 1'b0;
        end else begin
            sync1 <= neopixel_data;
            s     <= sync1;
            s_d   <= s;
        end
    end

    assign rise = s & ~s_d;
    assign fall = ~s & s_d;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) state <= WAIT_LATCH;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_LATCH: if (wait_done) state_nxt = IDLE;
            IDLE:       if (rise) state_nxt = HIGH;
            HIGH:       if (fall) state_nxt = LOW;
            LOW: begin
                if (rise)           state_nxt = HIGH;
                else if (latch_hit) state_nxt = IDLE;
            end
            default:    state_nxt = WAIT_LATCH;
        endcase
    end

    always_comb begin
        bit_ok    = 1'b0;
        bit_bad   = 1'b0;
        latch_hit = 1'b0;
        wait_done = 1'b0;
        bit_val   = (hcnt >= H_ONE);
        sr_nxt    = {sr[22:0], bit_val};
        case (state)
            WAIT_LATCH: wait_done = !s && (lcnt == L_LAST);
            HIGH: begin
                if (fall) begin
                    if (hcnt < H_MIN || hcnt > H_MAX) bit_bad = 1'b1;
                    else                              bit_ok  = 1'b1;
                end
            end
            LOW:        latch_hit = !s && (lcnt == L_LAST);
            default:    ;
        endcase
    end

    assign err_evt = bit_bad | (latch_hit & (bitcnt != 5'd0));

    // Colour outputs load on the falling-edge cycle of bit 24, so they appear the cycle after.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            hcnt        <= '0;
            lcnt        <= '0;
            sr          <= '0;
            bitcnt      <= '0;
            word_idx    <= '0;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            pixel_index <= '0;
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;
            case (state)
                WAIT_LATCH: begin
                    if (s || wait_done) lcnt <= '0;
                    else                lcnt <= lcnt + 1'b1;
                end
                IDLE: begin
                    if (rise) begin
                        hcnt <= HW'(1);
                        lcnt <= '0;
                    end
                end
                HIGH: begin
                    if (!fall) begin
                        if (hcnt != H_SAT) hcnt <= hcnt + 1'b1;
                    end else begin
                        hcnt <= '0;
                        lcnt <= LW'(1);
                        if (bit_ok) begin
                            sr <= sr_nxt;
                            if (bitcnt == 5'd23) begin
                                bitcnt      <= '0;
                                green       <= sr_nxt[23:16];
                                red         <= sr_nxt[15:8];
                                blue        <= sr_nxt[7:0];
                                pixel_index <= word_idx;
                                word_idx    <= word_idx + 1'b1;
                                pixel_valid <= 1'b1;
                            end else begin
                                bitcnt <= bitcnt + 1'b1;
                            end
                        end
                    end
                end
                LOW: begin
                    if (rise) begin
                        hcnt <= HW'(1);
                        lcnt <= '0;
                    end else if (latch_hit) begin
                        frame_done  <= 1'b1;
                        bitcnt      <= '0;
                        word_idx    <= '0;
                        pixel_index <= '0;
                        lcnt        <= '0;
                    end else if (lcnt != L_SAT) begin
                        lcnt <= lcnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // A partial word at the latch re-arms the flag on the very cycle frame_done would clear it.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n)       error <= 1'b0;
        else if (err_evt)   error <= 1'b1;
        else if (latch_hit) error <= 1'b0;
    end

`ifdef NEOPIX_DEC_ERR_CNT_EN
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n)                           err_count <= '0;
        else if (err_evt && err_count != 8'hFF) err_count <= err_count + 1'b1;
    end
`endif

endmodule

// File: tb/tb_neopix_decoder.sv
// tb/tb_neopix_decoder.sv - directed table-driven bench for neopix_decoder
module tb_neopix_decoder;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       data;
    logic [7:0] red, green, blue;
    logic [2:0] pixel_index;
    logic       pixel_valid, frame_done, error;
`ifdef NEOPIX_DEC_ERR_CNT_EN
    logic [7:0] err_count;
`endif

    neopix_decoder dut (
        .CLOCK_50      (clk),
        .reset_n       (reset_n),
        .neopixel_data (data),
        .red           (red),
        .green         (green),
        .blue          (blue),
        .pixel_index   (pixel_index),
        .pixel_valid   (pixel_valid),
        .frame_done    (frame_done),
        .error         (error)
`ifdef NEOPIX_DEC_ERR_CNT_EN
        ,
        .err_count     (err_count)
`endif
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [23:0] word;
        logic [7:0]  g, r, b;
        logic [2:0]  idx;
    } vec_t;

    typedef struct {
        logic [7:0] g, r, b;
        logic [2:0] idx;
        int         lat;
    } cap_t;

    vec_t vec [12];
    cap_t cap_q[$];
    int   rd_ptr = 0;
    int   cyc = 0;
    int   last_fall = 0;
    int   fd_cnt = 0;
    int   overlap = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   fd_base;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (pixel_valid) cap_q.push_back('{green, red, blue, pixel_index, cyc - last_fall});
        if (frame_done) fd_cnt = fd_cnt + 1;
        if (pixel_valid && frame_done) overlap = overlap + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_word(input string nm, input logic [7:0] g, input logic [7:0] r,
                              input logic [7:0] b, input logic [2:0] idx);
        if (rd_ptr >= cap_q.size()) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: no pixel_valid seen, expected G=%h R=%h B=%h idx=%0d", nm, g, r, b, idx);
        end else begin
            chk({nm, "_green"}, 32'(cap_q[rd_ptr].g), 32'(g));
            chk({nm, "_red"},   32'(cap_q[rd_ptr].r), 32'(r));
            chk({nm, "_blue"},  32'(cap_q[rd_ptr].b), 32'(b));
            chk({nm, "_index"}, 32'(cap_q[rd_ptr].idx), 32'(idx));
            chk({nm, "_latency"}, 32'(cap_q[rd_ptr].lat), 32'd3);
            rd_ptr++;
        end
    endtask

    task automatic drive(input logic v, input int n);
        data = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        drive(1'b1, b ? 40 : 20);
        last_fall = cyc;
        drive(1'b0, b ? 22 : 42);
    endtask

    task automatic send_bits(input logic [23:0] w, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) send_bit(w[i]);
    endtask

    task automatic send_word(input logic [23:0] w);
        send_bits(w, 23, 0);
    endtask

    initial begin
        vec[0]  = '{24'h010203, 8'h01, 8'h02, 8'h03, 3'd0};
        vec[1]  = '{24'h102030, 8'h10, 8'h20, 8'h30, 3'd1};
        vec[2]  = '{24'hAA550F, 8'hAA, 8'h55, 8'h0F, 3'd2};
        vec[3]  = '{24'h123456, 8'h12, 8'h34, 8'h56, 3'd0};
        vec[4]  = '{24'h89ABCD, 8'h89, 8'hAB, 8'hCD, 3'd1};
        vec[5]  = '{24'hFEDCBA, 8'hFE, 8'hDC, 8'hBA, 3'd2};
        vec[6]  = '{24'h00FF00, 8'h00, 8'hFF, 8'h00, 3'd3};
        vec[7]  = '{24'h0F0F0F, 8'h0F, 8'h0F, 8'h0F, 3'd4};
        vec[8]  = '{24'hF0F0F0, 8'hF0, 8'hF0, 8'hF0, 3'd5};
        vec[9]  = '{24'h808080, 8'h80, 8'h80, 8'h80, 3'd6};
        vec[10] = '{24'h7F017F, 8'h7F, 8'h01, 8'h7F, 3'd7};
        vec[11] = '{24'hC3A55A, 8'hC3, 8'hA5, 8'h5A, 3'd0};

        data    = 1'b0;
        reset_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_red", 32'(red), 32'h0);
        chk("rst_green", 32'(green), 32'h0);
        chk("rst_blue", 32'(blue), 32'h0);
        chk("rst_index", 32'(pixel_index), 32'h0);
        chk("rst_valid", 32'(pixel_valid), 32'h0);
        chk("rst_frame_done", 32'(frame_done), 32'h0);
        chk("rst_error", 32'(error), 32'h0);
        reset_n = 1'b1;

        drive(1'b0, 2600);
        chk("wait_latch_no_frame_done", 32'(fd_cnt), 32'd0);

        send_word(24'hFF0000);
        drive(1'b0, 5);
        check_word("first_word", 8'hFF, 8'h00, 8'h00, 3'd0);
        drive(1'b0, 2600);
        chk("first_frame_done", 32'(fd_cnt), 32'd1);
        chk("first_error", 32'(error), 32'd0);

        for (int i = 0; i < 3; i++) send_word(vec[i].word);
        drive(1'b0, 2600);
        for (int i = 0; i < 3; i++) check_word($sformatf("frameA_w%0d", i), vec[i].g, vec[i].r, vec[i].b, vec[i].idx);
        chk("frameA_frame_done", 32'(fd_cnt), 32'd2);
        chk("frameA_error", 32'(error), 32'd0);

        for (int i = 3; i < 12; i++) send_word(vec[i].word);
        drive(1'b0, 2600);
        for (int i = 3; i < 12; i++) check_word($sformatf("frameB_w%0d", i - 3), vec[i].g, vec[i].r, vec[i].b, vec[i].idx);
        chk("frameB_frame_done", 32'(fd_cnt), 32'd3);
        chk("no_extra_words_B", 32'(cap_q.size() - rd_ptr), 32'd0);

        send_bits(24'hABCDEF, 23, 12);
        drive(1'b0, 2600);
        chk("partial_no_valid", 32'(cap_q.size() - rd_ptr), 32'd0);
        chk("partial_frame_done", 32'(fd_cnt), 32'd4);
        chk("partial_error", 32'(error), 32'd1);
        send_word(24'h0000FF);
        drive(1'b0, 5);
        chk("error_sticky", 32'(error), 32'd1);
        check_word("clean_after_partial", 8'h00, 8'h00, 8'hFF, 3'd0);
        drive(1'b0, 2600);
        chk("error_cleared", 32'(error), 32'd0);
        chk("clean_frame_done", 32'(fd_cnt), 32'd5);

        send_bits(24'hC33CA5, 23, 14);
        drive(1'b1, 4);
        drive(1'b0, 58);
        chk("glitch_error", 32'(error), 32'd1);
        send_bits(24'hC33CA5, 13, 0);
        drive(1'b0, 5);
        check_word("glitch_word", 8'hC3, 8'h3C, 8'hA5, 3'd0);
        send_bits(24'h669912, 23, 19);
        drive(1'b1, 80);
        drive(1'b0, 22);
        send_bits(24'h669912, 18, 0);
        drive(1'b0, 5);
        check_word("long_high_word", 8'h66, 8'h99, 8'h12, 3'd1);
        chk("long_high_error", 32'(error), 32'd1);
`ifdef NEOPIX_DEC_ERR_CNT_EN
        chk("err_count_two", 32'(err_count), 32'd2);
`endif
        drive(1'b0, 2600);
        chk("glitch_frame_error_clear", 32'(error), 32'd0);
        chk("glitch_frame_done", 32'(fd_cnt), 32'd6);
`ifdef NEOPIX_DEC_ERR_CNT_EN
        chk("err_count_kept", 32'(err_count), 32'd2);
`endif

        fd_base = fd_cnt;
        send_bits(24'h5A5A5A, 23, 15);
        drive(1'b1, 10);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midreset_red", 32'(red), 32'h0);
        chk("midreset_index", 32'(pixel_index), 32'h0);
        reset_n = 1'b1;
        drive(1'b1, 10);
        drive(1'b0, 42);
        send_word(24'h3C3C3C);
        drive(1'b0, 5);
        chk("midreset_no_valid", 32'(cap_q.size() - rd_ptr), 32'd0);
        drive(1'b0, 2600);
        chk("midreset_no_frame_done", 32'(fd_cnt), 32'(fd_base));
        send_word(24'h13579B);
        drive(1'b0, 5);
        check_word("after_reset_word", 8'h13, 8'h57, 8'h9B, 3'd0);

        chk("valid_frame_done_overlap", 32'(overlap), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
